// File: rtl/mul_repeated_add.sv
// Unsigned sequential multiplier: product = A * B formed by adding A into an
// accumulator B times, with operands loaded serially from a shared bus.
module mul_repeated_add #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] product,
    output logic             done,
    output logic             busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD_A,
        S_LOAD_B,
        S_CALC,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] p_q, p_d;
    logic             b_eqz;

    // B doubles as the remaining-iteration counter.
    assign b_eqz = (b_q == '0);

    always_comb begin
        // NOTE: every next-state value defaults to "hold" first so no branch can infer a latch.
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;

        case (state_q)
            S_IDLE: begin
                if (start) state_d = S_LOAD_A;
            end
            S_LOAD_A: begin
                a_d     = data_in;
                state_d = S_LOAD_B;
            end
            S_LOAD_B: begin
                b_d     = data_in;
                p_d     = '0;
                state_d = S_CALC;
            end
            S_CALC: begin
                if (b_eqz) begin
                    state_d = S_DONE;
                end else begin
                    p_d = p_q + a_q;
                    b_d = b_q - WIDTH'(1);
                end
            end
            S_DONE: begin
                // Start must be seen low before another operation can begin.
                if (!start) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: state updates use non-blocking assignments so all registers see pre-edge values.
        if (!rst_n) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            p_q     <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            p_q     <= p_d;
        end
    end

    assign product = p_q;
    assign done    = (state_q == S_DONE);
    assign busy    = (state_q == S_LOAD_A) || (state_q == S_LOAD_B) || (state_q == S_CALC);

endmodule

// File: tb/tb_mul_repeated_add.sv
// Self-checking bench for mul_repeated_add: a timing/arithmetic reference model
// checked every cycle, plus directed operations with hand-computed results.
module tb_mul_repeated_add;

    localparam int WIDTH   = 16;
    localparam int MAX_LAT = 400;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             start;
    logic [WIDTH-1:0] data_in;
    logic [WIDTH-1:0] product;
    logic             done;
    logic             busy;

    int checks   = 0;
    int failures = 0;

    mul_repeated_add #(.WIDTH(WIDTH)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .data_in (data_in),
        .product (product),
        .done    (done),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: counts edges since the accepted start edge (m_t) and
    // derives outputs from that count and the operands by plain arithmetic.
    bit               m_valid = 1'b0;
    bit               m_run   = 1'b0;
    bit               m_done  = 1'b0;
    int               m_t     = 0;
    logic [WIDTH-1:0] m_a     = '0;
    logic [WIDTH-1:0] m_b     = '0;
    logic [WIDTH-1:0] m_hold  = '0;

    function automatic logic [WIDTH-1:0] trunc_mul(input logic [WIDTH-1:0] a, input longint n);
        longint full;
        full = longint'(a) * n;
        return full[WIDTH-1:0];
    endfunction

    always @(posedge clk) begin
        if (!rst_n) begin
            m_valid <= 1'b1;
            m_run   <= 1'b0;
            m_done  <= 1'b0;
            m_hold  <= '0;
        end else if (m_run) begin
            m_t <= m_t + 1;
            if (m_t == 0) m_a <= data_in;
            if (m_t == 1) m_b <= data_in;
            if (m_t >= 2 && m_t == 2 + int'(m_b)) begin
                m_run  <= 1'b0;
                m_done <= 1'b1;
                m_hold <= trunc_mul(m_a, longint'(m_b));
            end
        end else if (m_done) begin
            if (!start) m_done <= 1'b0;
        end else if (start) begin
            m_run <= 1'b1;
            m_t   <= 0;
        end
    end

    always @(negedge clk) begin
        logic [WIDTH-1:0] exp_p;
        if (m_valid) begin
            if (m_run && m_t >= 2) exp_p = trunc_mul(m_a, longint'(m_t - 2));
            else                   exp_p = m_hold;
            check("cyc_product", 32'(product), 32'(exp_p));
            check("cyc_done", 32'(done), 32'(m_done));
            check("cyc_busy", 32'(busy), 32'(m_run));
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge where done is first seen.
    task automatic run_op(input string name, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b,
                          input int exp_p, input int exp_lat);
        int j;
        start = 1'b1;
        @(negedge clk);
        j = 0;
        data_in = a;
        @(negedge clk);
        j = 1;
        data_in = b;
        while (!done && j < MAX_LAT) begin
            @(negedge clk);
            j++;
        end
        check({name, "_latency"}, 32'(j), 32'(exp_lat));
        check({name, "_product"}, 32'(product), 32'(exp_p));
    endtask

    task automatic release_start(input string name);
        start = 1'b0;
        @(negedge clk);
        check({name, "_done_low"}, 32'(done), 32'd0);
    endtask

    initial begin
        rst_n   = 1'b0;
        start   = 1'b0;
        data_in = '0;
        repeat (3) @(negedge clk);
        check("rst_product", 32'(product), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // 17 x 5, done held while start stays high
        run_op("m17x5", 16'd17, 16'd5, 85, 8);
        repeat (3) @(negedge clk);
        check("m17x5_hold_done", 32'(done), 32'd1);
        check("m17x5_hold_product", 32'(product), 32'd85);
        release_start("m17x5");

        run_op("b0", 16'd1234, 16'd0, 0, 3);
        release_start("b0");

        run_op("m300x300", 16'd300, 16'd300, 24464, 303);
        release_start("m300x300");

        // Reset abandons a 17 x 5 in CALC
        start = 1'b1;
        @(negedge clk);
        data_in = 16'd17;
        @(negedge clk);
        data_in = 16'd5;
        repeat (4) @(negedge clk);
        check("abort_busy_before", 32'(busy), 32'd1);
        rst_n = 1'b0;
        start = 1'b0;
        @(negedge clk);
        check("abort_product", 32'(product), 32'd0);
        check("abort_done", 32'(done), 32'd0);
        check("abort_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        run_op("m7x3", 16'd7, 16'd3, 21, 6);
        release_start("m7x3");

        // Back-to-back with start low for a single cycle
        run_op("bb17x5", 16'd17, 16'd5, 85, 8);
        release_start("bb17x5");
        run_op("bb9x4", 16'd9, 16'd4, 36, 7);
        release_start("bb9x4");

        run_op("a0", 16'd0, 16'd10, 0, 13);
        release_start("a0");

        // Wrap-around: 65535 x 2 = 131070 mod 65536
        run_op("wrap", 16'hFFFF, 16'd2, 65534, 5);
        release_start("wrap");

        repeat (2) @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
